// File: rtl/top.sv
// Keypad-driven three-motor dispenser: 4x4 keypad scan, 3-digit entry, muxed 7-seg display,
// per-digit motor timers. Define STAR_CLEAR_EN to make '*' clear the entry while idle.
module top #(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned DISP_DIV    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic [3:0] fila,
    output logic [3:0] col,
    output logic [6:0] segmentos,
    output logic [2:0] enable,
    output logic [2:0] Motores
);

    localparam int unsigned MotW = $clog2(9 * UNIT_CYCLES + 1);
    localparam int unsigned DivW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

    typedef enum logic {StIdle, StLoad} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             col_q;
    logic [3:0]             fila_prev_q;
    logic                   enter_prev_q;
    logic [2:0][3:0]        dig_q, dig_d;
    logic [1:0]             count_q, count_d;
    logic [2:0][MotW-1:0]   mot_q, mot_d;
    logic [DivW-1:0]        div_q;
    logic [2:0]             enable_q;

    logic       press, enter_rise, key_digit, key_star;
    logic [1:0] row_idx, col_idx;
    logic [3:0] key_val;
    logic [3:0] disp_dig;

    assign press      = (fila != 4'b0) && (fila_prev_q == 4'b0);
    assign enter_rise = enter && !enter_prev_q;

    // Lowest set row bit wins when several rows are active.
    always_comb begin
        row_idx = 2'd3;
        if (fila[0])      row_idx = 2'd0;
        else if (fila[1]) row_idx = 2'd1;
        else if (fila[2]) row_idx = 2'd2;
        col_idx = 2'd0;
        case (col_q)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        key_val   = 4'd0;
        key_digit = 1'b1;
        key_star  = 1'b0;
        case ({row_idx, col_idx})
            4'h0: key_val = 4'd1;
            4'h1: key_val = 4'd2;
            4'h2: key_val = 4'd3;
            4'h4: key_val = 4'd4;
            4'h5: key_val = 4'd5;
            4'h6: key_val = 4'd6;
            4'h8: key_val = 4'd7;
            4'h9: key_val = 4'd8;
            4'hA: key_val = 4'd9;
            4'hD: key_val = 4'd0;
            4'hC: begin
                key_digit = 1'b0;
                key_star  = 1'b1;
            end
            default: key_digit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        count_d = count_q;
        mot_d   = mot_q;
        case (state_q)
            StIdle: begin
                // Enter takes priority over a simultaneous key press.
                if (enter_rise && (count_q != 2'd0)) begin
                    for (int i = 0; i < 3; i++) begin
                        mot_d[i] = MotW'(32'(dig_q[i]) * UNIT_CYCLES);
                    end
                    state_d = StLoad;
                end else if (press && key_digit) begin
                    if (count_q == 2'd3) begin
                        dig_d   = '0;
                        count_d = 2'd0;
                    end else begin
                        dig_d   = {dig_q[1], dig_q[0], key_val};
                        count_d = count_q + 2'd1;
                    end
                end
`ifdef STAR_CLEAR_EN
                else if (press && key_star) begin
                    dig_d   = '0;
                    count_d = 2'd0;
                end
`endif
            end
            StLoad: begin
                for (int i = 0; i < 3; i++) begin
                    if (mot_q[i] != '0) mot_d[i] = mot_q[i] - MotW'(1);
                end
                if (mot_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            col_q        <= 4'b0001;
            fila_prev_q  <= 4'b0;
            enter_prev_q <= 1'b0;
            dig_q        <= '0;
            count_q      <= 2'd0;
            mot_q        <= '0;
            div_q        <= '0;
            enable_q     <= 3'b001;
        end else begin
            state_q      <= state_d;
            col_q        <= {col_q[2:0], col_q[3]};
            fila_prev_q  <= fila;
            enter_prev_q <= enter;
            dig_q        <= dig_d;
            count_q      <= count_d;
            mot_q        <= mot_d;
            if (div_q == DivW'(DISP_DIV - 1)) begin
                div_q    <= '0;
                enable_q <= {enable_q[1:0], enable_q[2]};
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

    always_comb begin
        disp_dig = dig_q[0];
        case (enable_q)
            3'b010:  disp_dig = dig_q[1];
            3'b100:  disp_dig = dig_q[2];
            default: disp_dig = dig_q[0];
        endcase
        case (disp_dig)
            4'd0:    segmentos = 7'b0111111;
            4'd1:    segmentos = 7'b0000110;
            4'd2:    segmentos = 7'b1011011;
            4'd3:    segmentos = 7'b1001111;
            4'd4:    segmentos = 7'b1100110;
            4'd5:    segmentos = 7'b1101101;
            4'd6:    segmentos = 7'b1111101;
            4'd7:    segmentos = 7'b0000111;
            4'd8:    segmentos = 7'b1111111;
            4'd9:    segmentos = 7'b1101111;
            default: segmentos = 7'b0000000;
        endcase
    end

    assign col    = col_q;
    assign enable = enable_q;
    for (genvar i = 0; i < 3; i++) begin : g_mot
        assign Motores[i] = (mot_q[i] != '0);
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for the keypad dispenser top: entry, display, motor timing, reset and '*' clear.
module tb_top;

    localparam int unsigned UNIT_CYCLES = 4;
    localparam int unsigned DISP_DIV    = 4;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enter = 1'b0;
    logic [3:0] fila = 4'b0;
    logic [3:0] col;
    logic [6:0] segmentos;
    logic [2:0] enable;
    logic [2:0] Motores;

    int errors = 0;
    int checks = 0;

    top #(
        .UNIT_CYCLES(UNIT_CYCLES),
        .DISP_DIV   (DISP_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enter    (enter),
        .fila     (fila),
        .col      (col),
        .segmentos(segmentos),
        .enable   (enable),
        .Motores  (Motores)
    );

    always #5 clk = ~clk;

    // One-clock key pulse landing while the requested column is driven.
    task automatic press(input int row, input int c);
        logic [3:0] want;
        want = 4'b0001 << c;
        for (int i = 0; i < 8 && col !== want; i++) @(negedge clk);
        checks++;
        if (col !== want) begin
            errors++;
            $display("FAIL press_col_wait: col=%b required %b", col, want);
        end
        fila = 4'b0001 << row;
        @(negedge clk);
        fila = 4'b0;
        @(negedge clk);
    endtask

    task automatic read_disp(output logic [6:0] h, output logic [6:0] t, output logic [6:0] u);
        h = 'x;
        t = 'x;
        u = 'x;
        for (int i = 0; i < 3 * DISP_DIV + 2; i++) begin
            @(negedge clk);
            case (enable)
                3'b001:  u = segmentos;
                3'b010:  t = segmentos;
                3'b100:  h = segmentos;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [6:0] h, t, u;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (col !== 4'b0001) begin errors++; $display("FAIL reset_col: got %b want 0001", col); end
        checks++;
        if (enable !== 3'b001) begin errors++; $display("FAIL reset_enable: got %b want 001", enable); end
        checks++;
        if (Motores !== 3'b000) begin errors++; $display("FAIL reset_motores: got %b want 000", Motores); end
        checks++;
        if (segmentos !== S0) begin errors++; $display("FAIL reset_seg: got %b want %b", segmentos, S0); end
        reset = 1'b1;
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== {S0, S0, S0}) begin
            errors++;
            $display("FAIL reset_display: got %b %b %b want all %b", h, t, u, S0);
        end
    endtask

    task automatic test_entry();
        logic [6:0] h, t, u;
        press(0, 1);
        press(1, 1);
        press(2, 1);
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== {S2, S5, S8}) begin
            errors++;
            $display("FAIL entry_258: got %b %b %b want %b %b %b", h, t, u, S2, S5, S8);
        end
    endtask

    task automatic test_load();
        int cnt [3];
        logic [6:0] h, t, u;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        @(negedge clk);
        enter = 1'b1;
        checks++;
        if (Motores !== 3'b000) begin errors++; $display("FAIL load_pre_edge: got %b want 000", Motores); end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (Motores !== 3'b111) begin
                    errors++;
                    $display("FAIL load_rise: got %b want 111", Motores);
                end
            end
            for (int i = 0; i < 3; i++) if (Motores[i]) cnt[i]++;
            case (cyc)
                0:  enter = 1'b0;
                4:  fila = 4'b0001;
                5:  fila = 4'b0;
                8:  enter = 1'b1;
                9:  enter = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (cnt[2] != 8) begin errors++; $display("FAIL load_m2_len: got %0d want 8", cnt[2]); end
        checks++;
        if (cnt[1] != 20) begin errors++; $display("FAIL load_m1_len: got %0d want 20", cnt[1]); end
        checks++;
        if (cnt[0] != 32) begin errors++; $display("FAIL load_m0_len: got %0d want 32", cnt[0]); end
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== {S2, S5, S8}) begin
            errors++;
            $display("FAIL load_keeps_digits: got %b %b %b want %b %b %b", h, t, u, S2, S5, S8);
        end
    endtask

    task automatic test_overflow();
        logic [6:0] h, t, u;
        press(0, 1);
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== {S0, S0, S0}) begin
            errors++;
            $display("FAIL overflow_clear: got %b %b %b want all %b", h, t, u, S0);
        end
        press(0, 1);
        press(0, 1);
        press(0, 1);
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== {S2, S2, S2}) begin
            errors++;
            $display("FAIL overflow_222: got %b %b %b want all %b", h, t, u, S2);
        end
    endtask

    task automatic test_enter_count0();
        int on_cnt;
        on_cnt = 0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        enter = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Motores !== 3'b000) on_cnt++;
        end
        enter = 1'b0;
        checks++;
        if (on_cnt != 0) begin errors++; $display("FAIL enter_count0: motor-on cycles %0d want 0", on_cnt); end
    endtask

    task automatic test_reset_mid_load();
        logic [6:0] h, t, u;
        press(2, 2);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (Motores !== 3'b001) begin errors++; $display("FAIL midload_run: got %b want 001", Motores); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Motores !== 3'b000) begin errors++; $display("FAIL midload_async: got %b want 000", Motores); end
        @(negedge clk);
        reset = 1'b1;
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== {S0, S0, S0}) begin
            errors++;
            $display("FAIL midload_display: got %b %b %b want all %b", h, t, u, S0);
        end
    endtask

    task automatic test_star();
        logic [6:0] h, t, u;
        logic [20:0] want;
        press(1, 0);
        press(2, 0);
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== {S0, S4, S7}) begin
            errors++;
            $display("FAIL star_pre_047: got %b %b %b want %b %b %b", h, t, u, S0, S4, S7);
        end
        press(3, 0);
`ifdef STAR_CLEAR_EN
        want = {S0, S0, S0};
`else
        want = {S0, S4, S7};
`endif
        read_disp(h, t, u);
        checks++;
        if ({h, t, u} !== want) begin
            errors++;
            $display("FAIL star_key: got %b %b %b want %b", h, t, u, want);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_load();
        test_overflow();
        test_enter_count0();
        test_reset_mid_load();
        test_star();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
